fp_round_pipe: RTL

FP_ROUND_PIPE -- requirements
Module: fp_round_pipe

---
 rtl/fp_round_pipe.sv | 190 +++++++++++++++++++
 1 files changed

// File: rtl/fp_round_pipe.sv
// Two-stage IEEE-style rounding pipeline: stage 1 captures the operand and the
// increment decision, stage 2 applies it and renormalises. Optional flags: FP_ROUND_FLAGS_EN.
module fp_round_pipe #(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     valid_i,
    output logic                     ready_o,
    input  logic                     sign_i,
    input  logic [EXP_W-1:0]         exp_i,
    input  logic [MAN_W:0]           man_i,
    input  logic [2:0]               grs_i,
    input  logic [2:0]               rmode_i,
    output logic                     valid_o,
    input  logic                     ready_i,
    output logic [EXP_W+MAN_W:0]     data_o,
    output logic [2:0]               flags_o
);

    localparam logic [EXP_W-1:0] EXP_ONES = {EXP_W{1'b1}};
    localparam logic [EXP_W-1:0] EXP_ONE  = {{(EXP_W-1){1'b0}}, 1'b1};
    localparam logic [EXP_W-1:0] EXP_ZERO = {EXP_W{1'b0}};

    function automatic logic round_inc(input logic [2:0] rm, input logic s,
                                       input logic [2:0] grs, input logic lsb);
        logic inc;
        case (rm)
            3'b000:  inc = grs[2] & (grs[1] | grs[0] | lsb);
            3'b001:  inc = 1'b0;
            3'b010:  inc = s & (|grs);
            3'b011:  inc = ~s & (|grs);
            3'b100:  inc = grs[2];
            default: inc = 1'b0;
        endcase
        return inc;
    endfunction

    logic                 s1_valid_q, s1_valid_d;
    logic                 s1_sign_q,  s1_sign_d;
    logic [EXP_W-1:0]     s1_exp_q,   s1_exp_d;
    logic [MAN_W:0]       s1_man_q,   s1_man_d;
    logic                 s1_inc_q,   s1_inc_d;
    logic                 s2_valid_q, s2_valid_d;
    logic [EXP_W+MAN_W:0] data_q,     data_d;
`ifdef FP_ROUND_FLAGS_EN
    logic                 s1_inv_q,   s1_inv_d;
    logic                 s1_inx_q,   s1_inx_d;
    logic [2:0]           flags_q,    flags_d;
`endif

    logic                 accept;
    logic                 s2_load;
    logic                 in_special;
    logic                 s1_special;
    logic [MAN_W+1:0]     sum;
    logic [EXP_W-1:0]     res_exp;
    logic [MAN_W-1:0]     res_frac;
    logic                 ovf;

    // Stage 1 frees exactly when stage 2 is empty or draining.
    assign s2_load    = s1_valid_q & (~s2_valid_q | ready_i);
    assign ready_o    = ~s1_valid_q | ~s2_valid_q | ready_i;
    assign accept     = valid_i & ready_o;
    assign in_special = (exp_i == EXP_ONES);
    assign s1_special = (s1_exp_q == EXP_ONES);

    // Stage 1: capture operand and the increment decision.
    always_comb begin
        s1_valid_d = s1_valid_q;
        s1_sign_d  = s1_sign_q;
        s1_exp_d   = s1_exp_q;
        s1_man_d   = s1_man_q;
        s1_inc_d   = s1_inc_q;
`ifdef FP_ROUND_FLAGS_EN
        s1_inv_d   = s1_inv_q;
        s1_inx_d   = s1_inx_q;
`endif
        if (accept) begin
            s1_valid_d = 1'b1;
            s1_sign_d  = sign_i;
            s1_exp_d   = exp_i;
            s1_man_d   = man_i;
            if (in_special) begin
                s1_inc_d = 1'b0;
`ifdef FP_ROUND_FLAGS_EN
                s1_inv_d = 1'b0;
                s1_inx_d = 1'b0;
`endif
            end else begin
                s1_inc_d = round_inc(rmode_i, sign_i, grs_i, man_i[0]);
`ifdef FP_ROUND_FLAGS_EN
                s1_inv_d = (rmode_i > 3'd4);
                s1_inx_d = |grs_i;
`endif
            end
        end else if (s2_load) begin
            s1_valid_d = 1'b0;
        end else begin
            s1_valid_d = s1_valid_q;
        end
    end

    // Stage 2 datapath: add the increment, renormalise, saturate to infinity.
    always_comb begin
        sum      = {1'b0, s1_man_q} + {{(MAN_W+1){1'b0}}, s1_inc_q};
        res_exp  = s1_exp_q;
        res_frac = sum[MAN_W-1:0];
        ovf      = 1'b0;
        if (s1_special) begin
            res_exp  = s1_exp_q;
            res_frac = s1_man_q[MAN_W-1:0];
        end else if (sum[MAN_W+1]) begin
            res_exp  = s1_exp_q + EXP_ONE;
            res_frac = {MAN_W{1'b0}};
        end else if ((s1_exp_q == EXP_ZERO) && sum[MAN_W]) begin
            res_exp  = EXP_ONE;
            res_frac = sum[MAN_W-1:0];
        end else begin
            res_exp  = s1_exp_q;
            res_frac = sum[MAN_W-1:0];
        end
        if (!s1_special && (res_exp == EXP_ONES)) begin
            ovf      = 1'b1;
            res_frac = {MAN_W{1'b0}};
        end else begin
            ovf      = 1'b0;
        end
    end

    // Stage 2 next-state: load on advance, hold while stalled.
    always_comb begin
        data_d = data_q;
`ifdef FP_ROUND_FLAGS_EN
        flags_d = flags_q;
`endif
        if (s2_load) begin
            s2_valid_d = 1'b1;
            data_d     = {s1_sign_q, res_exp, res_frac};
`ifdef FP_ROUND_FLAGS_EN
            flags_d    = {s1_inv_q, ovf, s1_inx_q | ovf};
`endif
        end else if (ready_i) begin
            s2_valid_d = 1'b0;
        end else begin
            s2_valid_d = s2_valid_q;
        end
    end

    // Pipeline registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            s1_valid_q <= 1'b0;
            s1_sign_q  <= 1'b0;
            s1_exp_q   <= {EXP_W{1'b0}};
            s1_man_q   <= {(MAN_W+1){1'b0}};
            s1_inc_q   <= 1'b0;
            s2_valid_q <= 1'b0;
            data_q     <= {(EXP_W+MAN_W+1){1'b0}};
`ifdef FP_ROUND_FLAGS_EN
            s1_inv_q   <= 1'b0;
            s1_inx_q   <= 1'b0;
            flags_q    <= 3'b000;
`endif
        end else begin
            s1_valid_q <= s1_valid_d;
            s1_sign_q  <= s1_sign_d;
            s1_exp_q   <= s1_exp_d;
            s1_man_q   <= s1_man_d;
            s1_inc_q   <= s1_inc_d;
            s2_valid_q <= s2_valid_d;
            data_q     <= data_d;
`ifdef FP_ROUND_FLAGS_EN
            s1_inv_q   <= s1_inv_d;
            s1_inx_q   <= s1_inx_d;
            flags_q    <= flags_d;
`endif
        end
    end

    assign valid_o = s2_valid_q;
    assign data_o  = data_q;
`ifdef FP_ROUND_FLAGS_EN
    assign flags_o = flags_q;
`else
    assign flags_o = 3'b000;
`endif

endmodule
